dvp_pixel_packer: RTL and testbench

- Upstream stage of the DAQ SPI slave path.
- Captures the image sensor's DVP byte stream (cam_pclk/cam_vsync/cam_href/cam_data), resynchronised into sys_clk.
- Writes pixel bytes into the dual-clock FIFO that the SPI slave drains, and frames the stream into fixed packages of package_size bytes.
- Raises intr_out to the host MCU whenever at least one complete package is waiting.

---
 rtl/dvp_pixel_packer.sv | 173 +++++++++++++++++
 tb/tb_dvp_pixel_packer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pixel_packer.sv
// DVP byte-stream capture into the SPI-side write FIFO, framed into package_size-byte packages with a host interrupt.
// Optional build macro DVP_FRAME_HEADER_EN prepends 8'hA5 and the frame counter to every frame.
module dvp_pixel_packer #(
  parameter int                    data_width   = 8,
  parameter int                    package_size = 2000,
  parameter logic [data_width-1:0] PAD_BYTE     = '0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic                  cam_pclk,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [data_width-1:0] cam_data,
  input  logic                  fifo_wr_full,
  output logic                  fifo_wr_en,
  output logic [data_width-1:0] fifo_wr_data,
  input  logic                  intr_ack,
  output logic                  package_ready,
  output logic                  intr_out,
  output logic                  frame_active,
  output logic                  overflow
);
  localparam int            CW   = $clog2(package_size);
  localparam logic [CW-1:0] LAST = CW'(package_size - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_VS, CAPTURE, PAD
`ifdef DVP_FRAME_HEADER_EN
    , HEADER
`endif
  } state_t;

  logic                  pclk_s1, pclk_s2, pclk_s3, vs_s1, vs_s2, vs_s3, href_s1, href_s2;
  logic [data_width-1:0] data_s1, data_s2, byte_q;
  logic                  stb_q, fs_q, fe_q;
  state_t                state, state_d;
  logic [CW-1:0]         byte_cnt;
  logic                  wr_d, ovf_set, start, active_d, wrap_q;
  logic [data_width-1:0] wr_dat_d;
  logic [7:0]            frame_cnt;
  logic [3:0]            pending;
  logic                  inc, dec;
`ifdef DVP_FRAME_HEADER_EN
  logic                  hdr_idx, hdr_idx_d;
`endif

  // Every cam_* signal sees the same two-flop delay, so data stays aligned with its strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {pclk_s1, pclk_s2, pclk_s3} <= '0;
      {vs_s1, vs_s2, vs_s3}       <= '0;
      {href_s1, href_s2}          <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
      byte_q  <= '0;
      stb_q   <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      pclk_s1 <= cam_pclk;  pclk_s2 <= pclk_s1; pclk_s3 <= pclk_s2;
      vs_s1   <= cam_vsync; vs_s2   <= vs_s1;   vs_s3   <= vs_s2;
      href_s1 <= cam_href;  href_s2 <= href_s1;
      data_s1 <= cam_data;  data_s2 <= data_s1;
      byte_q  <= data_s2;
      stb_q   <= pclk_s2 & ~pclk_s3 & href_s2;
      fs_q    <= ~vs_s2 & vs_s3;
      fe_q    <= vs_s2 & ~vs_s3;
    end
  end

  always_comb begin
    state_d  = state;
    wr_d     = 1'b0;
    wr_dat_d = byte_q;
    ovf_set  = 1'b0;
    start    = 1'b0;
`ifdef DVP_FRAME_HEADER_EN
    hdr_idx_d = hdr_idx;
`endif
    case (state)
      IDLE: if (enable) state_d = WAIT_VS;
      WAIT_VS: begin
        if (!enable) state_d = IDLE;
        else if (fs_q) begin
          start = 1'b1;
`ifdef DVP_FRAME_HEADER_EN
          state_d   = HEADER;
          hdr_idx_d = 1'b0;
`else
          state_d = CAPTURE;
`endif
        end
      end
`ifdef DVP_FRAME_HEADER_EN
      HEADER: begin
        if (stb_q) ovf_set = 1'b1;
        if (!fifo_wr_full) begin
          wr_d      = 1'b1;
          wr_dat_d  = hdr_idx ? data_width'(frame_cnt) : data_width'(8'hA5);
          hdr_idx_d = ~hdr_idx;
          if (hdr_idx) state_d = CAPTURE;
        end
      end
`endif
      CAPTURE: begin
        if (stb_q) begin
          if (!fifo_wr_full) wr_d = 1'b1;
          else               ovf_set = 1'b1;
        end
        // Pad only if the count is non-zero after any write landing this same cycle.
        if (fe_q) state_d = (wr_d ? (byte_cnt != LAST) : (byte_cnt != '0)) ? PAD : WAIT_VS;
      end
      PAD: begin
        wr_dat_d = PAD_BYTE;
        if (!fifo_wr_full) begin
          wr_d = 1'b1;
          if (byte_cnt == LAST) state_d = WAIT_VS;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d == CAPTURE) || (state_d == PAD);
`ifdef DVP_FRAME_HEADER_EN
    if (state_d == HEADER) active_d = 1'b1;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= '0;
      wrap_q        <= 1'b0;
      package_ready <= 1'b0;
      frame_cnt     <= '0;
      overflow      <= 1'b0;
      frame_active  <= 1'b0;
`ifdef DVP_FRAME_HEADER_EN
      hdr_idx       <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      fifo_wr_en    <= wr_d;
      if (wr_d) fifo_wr_data <= wr_dat_d;
      wrap_q        <= wr_d && (byte_cnt == LAST);
      package_ready <= wrap_q;
      if (wr_d) byte_cnt <= (byte_cnt == LAST) ? '0 : byte_cnt + 1'b1;
      if (start) frame_cnt <= frame_cnt + 8'd1;
      if (state_d == IDLE && state != IDLE) overflow <= 1'b0;
      else if (ovf_set)                     overflow <= 1'b1;
      frame_active  <= active_d;
`ifdef DVP_FRAME_HEADER_EN
      hdr_idx       <= hdr_idx_d;
`endif
    end
  end

  assign inc = package_ready;
  assign dec = intr_ack && (pending != 4'd0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending  <= '0;
      intr_out <= 1'b0;
    end else begin
      if (inc && !dec && pending != 4'd15) pending <= pending + 4'd1;
      else if (dec && !inc)                pending <= pending - 4'd1;
      intr_out <= (pending != 4'd0);
    end
  end
endmodule

// File: tb/tb_dvp_pixel_packer.sv
// Directed bench for dvp_pixel_packer with package_size=10; each scenario task checks its own results.
module tb_dvp_pixel_packer;
  logic       sys_clk, sys_rst_n, enable, cam_pclk, cam_vsync, cam_href, fifo_wr_full, intr_ack;
  logic [7:0] cam_data, fifo_wr_data;
  logic       fifo_wr_en, package_ready, intr_out, frame_active, overflow;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] wq[$];
  int         pr_cnt = 0;

  dvp_pixel_packer #(.data_width(8), .package_size(10), .PAD_BYTE(8'h00)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .fifo_wr_full(fifo_wr_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .intr_ack(intr_ack), .package_ready(package_ready), .intr_out(intr_out),
    .frame_active(frame_active), .overflow(overflow)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (fifo_wr_en) wq.push_back(fifo_wr_data);
      if (package_ready) pr_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_log();
    wq.delete();
    pr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic full);
    @(negedge sys_clk);
    fifo_wr_full = full;
    cam_data = d;
    cam_href = 1'b1;
    cam_pclk = 1'b0;
    cyc(4);
    cam_pclk = 1'b1;
    cyc(4);
  endtask

  task automatic end_line();
    @(negedge sys_clk);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    fifo_wr_full = 1'b0;
    cyc(10);
  endtask

  task automatic send_line(input int first, input int n);
    for (int i = 0; i < n; i++) send_byte(8'(first + i), 1'b0);
    end_line();
  endtask

  task automatic frame_start();
    @(negedge sys_clk);
    cam_vsync = 1'b0;
    cyc(20);
  endtask

  task automatic frame_end();
    @(negedge sys_clk);
    cam_vsync = 1'b1;
    cyc(40);
  endtask

  task automatic ack();
    @(negedge sys_clk);
    intr_ack = 1'b1;
    @(negedge sys_clk);
    intr_ack = 1'b0;
    cyc(3);
  endtask

  task automatic check_stream(input string name, input logic [7:0] exp[$]);
    logic [7:0] got;
    n_cmp++;
    if (wq.size() !== exp.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d expected %0d", name, wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < wq.size()) ? wq[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL %s byte %0d: got %h expected %h", name, i, got, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    cyc(3);
    #1;
    n_cmp++;
    if ({fifo_wr_en, fifo_wr_data, package_ready, intr_out, frame_active, overflow} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {fifo_wr_en, fifo_wr_data, package_ready, intr_out, frame_active, overflow});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    enable = 1'b1;
    cyc(10);
  endtask

  task automatic test_two_lines();
    logic [7:0] exp[$];
    clear_log();
    for (int i = 0; i < 20; i++) exp.push_back(8'(i));
    frame_start();
    n_cmp++;
    if (frame_active !== 1'b1) begin n_bad++; $display("FAIL two_lines active: got %b expected 1", frame_active); end
    send_line(0, 10);
    send_line(10, 10);
    frame_end();
    check_stream("two_lines", exp);
    n_cmp++;
    if (pr_cnt !== 2) begin n_bad++; $display("FAIL two_lines pkg_ready: got %0d expected 2", pr_cnt); end
    n_cmp++;
    if (intr_out !== 1'b1) begin n_bad++; $display("FAIL two_lines intr: got %b expected 1", intr_out); end
    n_cmp++;
    if (frame_active !== 1'b0) begin n_bad++; $display("FAIL two_lines idle: got %b expected 0", frame_active); end
  endtask

  task automatic test_ack();
    ack();
    n_cmp++;
    if (intr_out !== 1'b1) begin n_bad++; $display("FAIL ack_first: got %b expected 1", intr_out); end
    ack();
    n_cmp++;
    if (intr_out !== 1'b0) begin n_bad++; $display("FAIL ack_second: got %b expected 0", intr_out); end
    ack();
    n_cmp++;
    if (intr_out !== 1'b0) begin n_bad++; $display("FAIL ack_extra: got %b expected 0", intr_out); end
  endtask

  task automatic test_partial();
    logic [7:0] exp[$];
    clear_log();
    for (int i = 0; i < 13; i++) exp.push_back(8'(i));
    for (int i = 0; i < 7; i++) exp.push_back(8'h00);
    frame_start();
    send_line(0, 13);
    frame_end();
    check_stream("partial", exp);
    n_cmp++;
    if (pr_cnt !== 2) begin n_bad++; $display("FAIL partial pkg_ready: got %0d expected 2", pr_cnt); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL partial overflow: got %b expected 0", overflow); end
    ack();
    ack();
    n_cmp++;
    if (intr_out !== 1'b0) begin n_bad++; $display("FAIL partial intr_clear: got %b expected 0", intr_out); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    exp = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h00, 8'h00};
    clear_log();
    frame_start();
    for (int i = 0; i < 10; i++) send_byte(8'(i), (i == 2 || i == 3));
    end_line();
    frame_end();
    check_stream("overflow", exp);
    n_cmp++;
    if (pr_cnt !== 1) begin n_bad++; $display("FAIL overflow pkg_ready: got %0d expected 1", pr_cnt); end
    n_cmp++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow flag: got %b expected 1", overflow); end
    cyc(50);
    n_cmp++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow sticky: got %b expected 1", overflow); end
    @(negedge sys_clk);
    enable = 1'b0;
    cyc(10);
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL overflow idle_clear: got %b expected 0", overflow); end
    enable = 1'b1;
    cyc(5);
    ack();
    n_cmp++;
    if (intr_out !== 1'b0) begin n_bad++; $display("FAIL overflow intr_clear: got %b expected 0", intr_out); end
  endtask

  task automatic test_ack_collision();
    bit seen;
    clear_log();
    seen = 1'b0;
    fork
      begin
        frame_start();
        send_line(8'h20, 20);
        frame_end();
      end
      begin
        for (int k = 0; k < 3000 && !seen; k++) begin
          @(negedge sys_clk);
          if (fifo_wr_en && fifo_wr_data == 8'h33) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
          n_bad++;
          $display("FAIL collision last_write: got none expected 33 within 3000 cycles");
        end else begin
          @(negedge sys_clk);
          n_cmp++;
          if ({package_ready, intr_out} !== 2'b11) begin
            n_bad++;
            $display("FAIL collision pre: got %b expected 11", {package_ready, intr_out});
          end
          intr_ack = 1'b1;
          @(negedge sys_clk);
          intr_ack = 1'b0;
        end
      end
    join
    n_cmp++;
    if (pr_cnt !== 2) begin n_bad++; $display("FAIL collision pkg_ready: got %0d expected 2", pr_cnt); end
    n_cmp++;
    if (intr_out !== 1'b1) begin n_bad++; $display("FAIL collision intr_hold: got %b expected 1", intr_out); end
    ack();
    n_cmp++;
    if (intr_out !== 1'b0) begin n_bad++; $display("FAIL collision intr_clear: got %b expected 0", intr_out); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp[$];
    clear_log();
    frame_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_wr_en, fifo_wr_data, package_ready, intr_out, frame_active, overflow} !== 13'd0) begin
      n_bad++;
      $display("FAIL midreset outputs: got %h expected 0",
               {fifo_wr_en, fifo_wr_data, package_ready, intr_out, frame_active, overflow});
    end
    cyc(2);
    sys_rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h45 + i), 1'b0);
    end_line();
    frame_end();
    n_cmp++;
    if (wq.size() !== 0) begin n_bad++; $display("FAIL midreset stale_writes: got %0d expected 0", wq.size()); end
    exp = '{8'h50, 8'h51, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame_start();
    send_line(8'h50, 3);
    frame_end();
    check_stream("midreset_next", exp);
    n_cmp++;
    if (pr_cnt !== 1) begin n_bad++; $display("FAIL midreset pkg_ready: got %0d expected 1", pr_cnt); end
    ack();
  endtask

  task automatic test_header();
    logic [7:0] exp[$];
    for (int f = 1; f <= 2; f++) begin
      clear_log();
      exp.delete();
      exp.push_back(8'hA5);
      exp.push_back(8'(f));
      for (int i = 0; i < 8; i++) exp.push_back(8'(16 * (f - 1) + i));
      frame_start();
      send_line(16 * (f - 1), 8);
      frame_end();
      check_stream("header", exp);
      n_cmp++;
      if (pr_cnt !== 1) begin n_bad++; $display("FAIL header pkg_ready: got %0d expected 1", pr_cnt); end
      n_cmp++;
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL header overflow: got %b expected 0", overflow); end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    enable = 1'b0;
    cam_pclk = 1'b0;
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    cam_data = 8'h00;
    fifo_wr_full = 1'b0;
    intr_ack = 1'b0;
    test_reset();
`ifdef DVP_FRAME_HEADER_EN
    test_header();
`else
    test_two_lines();
    test_ack();
    test_partial();
    test_overflow();
    test_ack_collision();
    test_reset_midframe();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
